multicycle_cu: RTL and testbench

MULTICYCLE_CU -- requirements
Module: multicycle_cu

---
 rtl/multicycle_cu.sv | 270 +++++++++++++++++++++++++++
 tb/tb_multicycle_cu.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_cu.sv
// Multicycle MIPS-subset control unit: FSM sequencing fetch, decode,
// execute, memory and writeback with memory-wait timeout and retire count.
module multicycle_cu #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32,
    parameter int BYTE_OPS    = 1
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             mem_ready,
    input  logic             zero,
    input  logic             neg,
    output logic             pc_write,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_byte,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic             ext_zero,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wb_sel,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic [5:0]       alu_op,
    output logic             halted,
    output logic             illegal,
    output logic             mem_err,
    output logic [CNT_W-1:0] retired
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLEZ  = 6'b000110;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_SYS  = 6'b001100;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
        S_MEM_ADDR, S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH,
        S_JUMP, S_JUMP_R, S_HALT, S_ERROR
    } state_t;

    state_t          r_state;
    state_t          w_next;
    state_t          w_dec;
    logic [5:0]      r_op;
    logic [5:0]      r_fn;
    logic [WW-1:0]   r_wait;
    logic [CNT_W-1:0] r_retired;
    logic            r_illegal;
    logic            r_mem_err;
    logic            w_mem_st;
    logic            w_tmo;
    logic            w_taken;
    logic            w_byte;
    logic            w_imm_zx;
    logic [5:0]      w_imm_op;

    assign w_mem_st = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                      (r_state == S_MEM_WR);
    assign w_tmo    = (r_wait == WW'(MEM_TIMEOUT - 1));
    assign w_byte   = (r_op == OP_LB) || (r_op == OP_SB);

    always_comb begin
        w_dec = S_ERROR;
        case (opcode)
            OP_R: begin
                case (func)
                    F_ADD, F_ADDU, F_SUB, F_AND,
                    F_OR, F_XOR, F_SLT: w_dec = S_EXEC_R;
                    F_JR:               w_dec = S_JUMP_R;
                    F_SYS:              w_dec = S_HALT;
                    default:            w_dec = S_ERROR;
                endcase
            end
            OP_J, OP_JAL:                     w_dec = S_JUMP;
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: w_dec = S_BRANCH;
            OP_ADDI, OP_ADDIU, OP_ANDI,
            OP_ORI, OP_XORI:                  w_dec = S_EXEC_I;
            OP_LW, OP_SW:                     w_dec = S_MEM_ADDR;
            OP_LB, OP_SB: w_dec = (BYTE_OPS != 0) ? S_MEM_ADDR : S_ERROR;
            default:                          w_dec = S_ERROR;
        endcase
    end

    // ready in the final allowed wait cycle takes priority over timeout
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_FETCH: begin
                if (mem_ready)  w_next = S_DECODE;
                else if (w_tmo) w_next = S_ERROR;
            end
            S_DECODE:   w_next = w_dec;
            S_EXEC_R:   w_next = S_WB_R;
            S_WB_R:     w_next = S_FETCH;
            S_EXEC_I:   w_next = S_WB_I;
            S_WB_I:     w_next = S_FETCH;
            S_MEM_ADDR: w_next = r_op[3] ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready)  w_next = S_WB_MEM;
                else if (w_tmo) w_next = S_ERROR;
            end
            S_WB_MEM:   w_next = S_FETCH;
            S_MEM_WR: begin
                if (mem_ready)  w_next = S_FETCH;
                else if (w_tmo) w_next = S_ERROR;
            end
            S_BRANCH, S_JUMP, S_JUMP_R: w_next = S_FETCH;
            S_HALT:     w_next = S_HALT;
            default:    w_next = S_ERROR;
        endcase
    end

    always_comb begin
        w_imm_op = F_ADD;
        w_imm_zx = 1'b0;
        w_taken  = 1'b0;
        case (r_op)
            OP_ADDIU: w_imm_op = F_ADDU;
            OP_ANDI:  begin w_imm_op = F_AND; w_imm_zx = 1'b1; end
            OP_ORI:   begin w_imm_op = F_OR;  w_imm_zx = 1'b1; end
            OP_XORI:  begin w_imm_op = F_XOR; w_imm_zx = 1'b1; end
            default:  w_imm_op = F_ADD;
        endcase
        case (r_op[1:0])
            2'b00:   w_taken = zero;
            2'b01:   w_taken = !zero;
            2'b10:   w_taken = zero | neg;
            default: w_taken = !zero & !neg;
        endcase
    end

    always_comb begin
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_byte  = 1'b0;
        reg_write = 1'b0;
        alu_src_a = 1'b0;
        ext_zero  = 1'b0;
        reg_dst   = 2'd0;
        wb_sel    = 2'd0;
        alu_src_b = 2'd0;
        pc_src    = 2'd0;
        alu_op    = 6'd0;
        unique case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                alu_op    = F_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
                alu_op    = F_ADD;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = r_fn;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 2'd1;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_op    = w_imm_op;
                ext_zero  = w_imm_zx;
            end
            S_WB_I: reg_write = 1'b1;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_op    = F_ADD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                mem_byte = w_byte;
            end
            S_WB_MEM: begin
                reg_write = 1'b1;
                wb_sel    = 2'd1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                mem_byte  = w_byte;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = F_SUB;
                pc_src    = 2'd1;
                pc_write  = w_taken;
            end
            S_JUMP: begin
                pc_src   = 2'd2;
                pc_write = 1'b1;
                if (r_op == OP_JAL) begin
                    reg_write = 1'b1;
                    reg_dst   = 2'd2;
                    wb_sel    = 2'd2;
                end
            end
            S_JUMP_R: begin
                pc_src   = 2'd3;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state   <= S_FETCH;
            r_op      <= '0;
            r_fn      <= '0;
            r_wait    <= '0;
            r_retired <= '0;
            r_illegal <= 1'b0;
            r_mem_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op <= opcode;
                r_fn <= func;
            end
            r_wait <= (w_mem_st && w_next == r_state) ? r_wait + WW'(1) : '0;
            if (w_next == S_FETCH && r_state != S_FETCH)
                r_retired <= r_retired + CNT_W'(1);
            if (w_next == S_ERROR && r_state == S_DECODE)
                r_illegal <= 1'b1;
            if (w_next == S_ERROR && w_mem_st)
                r_mem_err <= 1'b1;
        end
    end

    assign halted  = (r_state == S_HALT);
    assign illegal = r_illegal;
    assign mem_err = r_mem_err;
    assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_cu.sv
// Randomized scoreboard bench for multicycle_cu: per-instruction
// transaction summaries checked against an instruction-level model.
module tb_multicycle_cu;
    localparam int TMO   = 4;
    localparam int NEVER = 99;

    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] func = '0;
    logic       mem_ready = 1'b0;
    logic       zero = 1'b0;
    logic       neg = 1'b0;

    logic pc_write, ir_write, mem_read, mem_write, mem_byte, reg_write;
    logic alu_src_a, ext_zero, halted, illegal, mem_err;
    logic [1:0] reg_dst, wb_sel, alu_src_b, pc_src;
    logic [5:0] alu_op;
    logic [1:0] retired;

    logic n_pc_write, n_ir_write, n_mem_read, n_mem_write, n_mem_byte;
    logic n_reg_write, n_alu_src_a, n_ext_zero, n_halted, n_illegal;
    logic n_mem_err;
    logic [1:0] n_reg_dst, n_wb_sel, n_alu_src_b, n_pc_src;
    logic [5:0] n_alu_op;
    logic [1:0] n_retired;

    always #5 clk = ~clk;

    multicycle_cu #(.MEM_TIMEOUT(TMO), .CNT_W(2), .BYTE_OPS(1)) dut (
        .clk(clk), .rst_b(rst_b), .opcode(opcode), .func(func),
        .mem_ready(mem_ready), .zero(zero), .neg(neg),
        .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
        .mem_write(mem_write), .mem_byte(mem_byte), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .ext_zero(ext_zero), .reg_dst(reg_dst),
        .wb_sel(wb_sel), .alu_src_b(alu_src_b), .pc_src(pc_src),
        .alu_op(alu_op), .halted(halted), .illegal(illegal),
        .mem_err(mem_err), .retired(retired)
    );

    multicycle_cu #(.MEM_TIMEOUT(TMO), .CNT_W(2), .BYTE_OPS(0)) dut_nb (
        .clk(clk), .rst_b(rst_b), .opcode(opcode), .func(func),
        .mem_ready(mem_ready), .zero(zero), .neg(neg),
        .pc_write(n_pc_write), .ir_write(n_ir_write),
        .mem_read(n_mem_read), .mem_write(n_mem_write),
        .mem_byte(n_mem_byte), .reg_write(n_reg_write),
        .alu_src_a(n_alu_src_a), .ext_zero(n_ext_zero),
        .reg_dst(n_reg_dst), .wb_sel(n_wb_sel), .alu_src_b(n_alu_src_b),
        .pc_src(n_pc_src), .alu_op(n_alu_op), .halted(n_halted),
        .illegal(n_illegal), .mem_err(n_mem_err), .retired(n_retired)
    );

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int fd;
        int md;
        bit z;
        bit n;
    } instr_t;

    typedef struct {
        int lat, mrd, mwr, irw, rw, dst, wb, pcw, ps;
        int mb, ez, aop, ret, hlt, ill, merr;
    } rec_t;

    instr_t iq[$];
    int     dq[$];
    rec_t   eq[$];
    int     checks = 0;
    int     errors = 0;
    int     mret = 0;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic bit is_mem(logic [5:0] op);
        return op == 6'h23 || op == 6'h2b || op == 6'h20 || op == 6'h28;
    endfunction

    // Instruction-level expectations: cycle counts, strobes, retire value
    function automatic rec_t model(instr_t i, int r0);
        rec_t e = '{default: 0};
        int f = i.fd + 2;
        bit rt = 1'b1;
        e.ret = r0;
        if (i.fd >= TMO) begin
            e.lat = TMO; e.mrd = TMO; e.merr = 1;
            return e;
        end
        e.irw = 1;
        e.mrd = i.fd + 1;
        if (i.op == 6'h00 && i.fn inside
            {6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2a}) begin
            e.lat = f + 2; e.rw = 1; e.dst = 1; e.aop = int'(i.fn);
        end else if (i.op == 6'h00 && i.fn == 6'h08) begin
            e.lat = f + 1; e.pcw = 1; e.ps = 3;
        end else if (i.op == 6'h00 && i.fn == 6'h0c) begin
            e.lat = f; e.hlt = 1; rt = 1'b0;
        end else if (i.op == 6'h02 || i.op == 6'h03) begin
            e.lat = f + 1; e.pcw = 1; e.ps = 2;
            if (i.op == 6'h03) begin e.rw = 1; e.dst = 2; e.wb = 2; end
        end else if (i.op inside {6'h04, 6'h05, 6'h06, 6'h07}) begin
            bit tk;
            case (i.op)
                6'h04:   tk = i.z;
                6'h05:   tk = !i.z;
                6'h06:   tk = i.z || i.n;
                default: tk = !i.z && !i.n;
            endcase
            e.lat = f + 1; e.aop = 'h22; e.pcw = int'(tk);
            e.ps = tk ? 1 : 0;
        end else if (i.op inside {6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e}) begin
            e.lat = f + 2; e.rw = 1;
            case (i.op)
                6'h08:   e.aop = 'h20;
                6'h09:   e.aop = 'h21;
                6'h0c:   e.aop = 'h24;
                6'h0d:   e.aop = 'h25;
                default: e.aop = 'h26;
            endcase
            e.ez = (i.op >= 6'h0c) ? 1 : 0;
        end else if (is_mem(i.op)) begin
            bit st = (i.op == 6'h2b || i.op == 6'h28);
            e.aop = 'h20;
            e.mb = (i.op == 6'h20 || i.op == 6'h28) ? 1 : 0;
            if (i.md >= TMO) begin
                e.lat = f + 1 + TMO; e.merr = 1; rt = 1'b0;
                if (st) e.mwr = TMO; else e.mrd += TMO;
            end else if (st) begin
                e.lat = f + 2 + i.md; e.mwr = i.md + 1;
            end else begin
                e.lat = f + 3 + i.md; e.mrd += i.md + 1;
                e.rw = 1; e.wb = 1;
            end
        end else begin
            e.lat = f; e.ill = 1; rt = 1'b0;
        end
        if (rt) e.ret = (r0 + 1) % 4;
        return e;
    endfunction

    function automatic instr_t mk(logic [5:0] op, logic [5:0] fn,
                                  int fd, int md, bit z, bit n);
        instr_t i;
        i.op = op; i.fn = fn; i.fd = fd; i.md = md; i.z = z; i.n = n;
        return i;
    endfunction

    function automatic instr_t rnd_instr();
        instr_t i;
        int k = int'($urandom_range(0, 22));
        i.op = 6'h00;
        i.fn = 6'($urandom);
        case (k)
            0: i.fn = 6'h20;  1: i.fn = 6'h21;  2: i.fn = 6'h22;
            3: i.fn = 6'h24;  4: i.fn = 6'h25;  5: i.fn = 6'h26;
            6: i.fn = 6'h2a;  7: i.fn = 6'h08;
            8: i.op = 6'h02;  9: i.op = 6'h03;
            10: i.op = 6'h04; 11: i.op = 6'h05;
            12: i.op = 6'h06; 13: i.op = 6'h07;
            14: i.op = 6'h08; 15: i.op = 6'h09; 16: i.op = 6'h0c;
            17: i.op = 6'h0d; 18: i.op = 6'h0e; 19: i.op = 6'h23;
            20: i.op = 6'h2b; 21: i.op = 6'h20;
            default: i.op = 6'h28;
        endcase
        i.fd = int'($urandom_range(0, TMO - 1));
        i.md = int'($urandom_range(0, TMO - 1));
        i.z = 1'($urandom_range(0, 1));
        i.n = i.z ? 1'b0 : 1'($urandom_range(0, 1));
        return i;
    endfunction

    task automatic issue(instr_t i);
        rec_t e = model(i, mret);
        iq.push_back(i);
        dq.push_back(i.fd);
        if (i.fd < TMO && is_mem(i.op)) dq.push_back(i.md);
        eq.push_back(e);
        mret = e.ret;
    endtask

    // Memory and IR model: answers requests after queued delays
    bit     busy = 1'b0;
    bit     pend = 1'b0;
    int     cnt = 0;
    int     cur = 0;
    instr_t nxt;
    initial forever begin
        @(posedge clk);
        #2;
        if (!rst_b) begin
            busy = 1'b0; pend = 1'b0; mem_ready = 1'b0;
        end else begin
            if (pend) begin
                opcode = nxt.op; func = nxt.fn;
                zero = nxt.z; neg = nxt.n; pend = 1'b0;
            end
            if (!busy && (mem_read || mem_write)) begin
                busy = 1'b1; cnt = 0;
                if (dq.size() > 0) cur = dq.pop_front();
                else cur = NEVER;
            end
            mem_ready = 1'b0;
            if (busy) begin
                mem_ready = (cnt == cur);
                cnt++;
                if (mem_ready) busy = 1'b0;
            end
            #1;
            if (ir_write) begin
                pend = 1'b1;
                if (iq.size() > 0) nxt = iq.pop_front();
                else nxt = mk(6'h3f, 6'h00, 0, 0, 1'b0, 1'b0);
            end
        end
    end

    rec_t acc = '{default: 0};
    int   prev_ret = 0;
    int   ex_cd = 0;
    bit   term = 1'b0;

    task automatic compare(rec_t a);
        rec_t e;
        if (eq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_txn: got lat=%0d expected none", a.lat);
            return;
        end
        e = eq.pop_front();
        chk("latency", a.lat, e.lat);
        chk("mem_read_cycles", a.mrd, e.mrd);
        chk("mem_write_cycles", a.mwr, e.mwr);
        chk("ir_write_cycles", a.irw, e.irw);
        chk("reg_write", a.rw, e.rw);
        chk("reg_dst", a.dst, e.dst);
        chk("wb_sel", a.wb, e.wb);
        chk("pc_write", a.pcw, e.pcw);
        chk("pc_src", a.ps, e.ps);
        chk("mem_byte", a.mb, e.mb);
        chk("ext_zero", a.ez, e.ez);
        chk("exec_alu_op", a.aop, e.aop);
        chk("retired", a.ret, e.ret);
        chk("halted", a.hlt, e.hlt);
        chk("illegal", a.ill, e.ill);
        chk("mem_err", a.merr, e.merr);
    endtask

    always @(negedge clk) begin
        if (!rst_b) begin
            acc = '{default: 0}; ex_cd = 0; prev_ret = 0; term = 1'b0;
        end else if (!term) begin
            if (int'(retired) != prev_ret || halted || illegal || mem_err) begin
                acc.ret = int'(retired); acc.hlt = int'(halted);
                acc.ill = int'(illegal); acc.merr = int'(mem_err);
                compare(acc);
                prev_ret = int'(retired);
                term = halted | illegal | mem_err;
                acc = '{default: 0}; ex_cd = 0;
            end
            if (!term) begin
                acc.lat++;
                if (mem_read) acc.mrd++;
                if (mem_write) acc.mwr++;
                if (ir_write) acc.irw++;
                if (mem_byte) acc.mb = 1;
                if (ext_zero) acc.ez = 1;
                if (reg_write) begin
                    acc.rw = 1; acc.dst = int'(reg_dst); acc.wb = int'(wb_sel);
                end
                if (pc_write && !ir_write) begin
                    acc.pcw = 1; acc.ps = int'(pc_src);
                end
                if (ir_write) ex_cd = 2;
                else if (ex_cd > 0) begin
                    ex_cd--;
                    if (ex_cd == 0) acc.aop = int'(alu_op);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_b = 1'b0;
        iq.delete(); dq.delete(); eq.delete();
        mret = 0;
        @(negedge clk);
        chk("rst_retired", int'(retired), 0);
        chk("rst_flags", int'({halted, illegal, mem_err}), 0);
        chk("rst_fetch_read", int'(mem_read), 1);
        chk("rst_strobes", int'({pc_write, ir_write, reg_write, mem_write}), 0);
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1 rst_b = 1'b1;
    endtask

    task automatic drain(int budget);
        int n = 0;
        while (eq.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (eq.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", eq.size());
        end
    endtask

    task automatic quiet(int h, int il, int me);
        repeat (4) begin
            @(negedge clk);
            chk("idle_strobes", int'({pc_write, ir_write, mem_read,
                mem_write, mem_byte, reg_write}), 0);
            chk("idle_flags", int'({halted, illegal, mem_err}),
                h * 4 + il * 2 + me);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        do_reset();
        repeat (5) issue(mk(6'h00, 6'h20, 0, 0, 1'b0, 1'b0));
        issue(mk(6'h20, 6'h00, 1, 2, 1'b0, 1'b0));
        issue(mk(6'h23, 6'h00, 0, 3, 1'b0, 1'b0));
        issue(mk(6'h04, 6'h00, 0, 0, 1'b1, 1'b0));
        issue(mk(6'h04, 6'h00, 2, 0, 1'b0, 1'b0));
        issue(mk(6'h28, 6'h00, 3, 3, 1'b0, 1'b0));
        repeat (30) issue(rnd_instr());
        issue(mk(6'h00, 6'h0c, 1, 0, 1'b0, 1'b0));
        release_rst();
        drain(3000);
        chk("nb_illegal", int'(n_illegal), 1);
        chk("nb_mem_err", int'(n_mem_err), 0);
        chk("nb_retired", int'(n_retired), 1);
        quiet(1, 0, 0);

        do_reset();
        issue(mk(6'h00, 6'h22, 2, 0, 1'b0, 1'b0));
        issue(mk(6'h3f, 6'h00, 1, 0, 1'b0, 1'b0));
        release_rst();
        drain(200);
        quiet(0, 1, 0);

        do_reset();
        issue(mk(6'h00, 6'h20, 0, 0, 1'b0, 1'b0));
        issue(mk(6'h00, 6'h20, NEVER, 0, 1'b0, 1'b0));
        release_rst();
        n = 0;
        while (eq.size() > 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("midwait_add_done", eq.size(), 1);
        @(negedge clk);
        chk("midwait_pre_retired", int'(retired), 1);
        chk("midwait_pre_mem_err", int'(mem_err), 0);
        #2 rst_b = 1'b0;
        #1;
        chk("midwait_rst_retired", int'(retired), 0);
        chk("midwait_rst_flags", int'({halted, illegal, mem_err}), 0);
        chk("midwait_rst_fetch", int'(mem_read), 1);
        iq.delete(); dq.delete(); eq.delete();
        mret = 0;
        issue(mk(6'h00, 6'h20, NEVER, 0, 1'b0, 1'b0));
        repeat (2) @(negedge clk);
        release_rst();
        drain(200);
        quiet(0, 0, 1);

        do_reset();
        issue(mk(6'h08, 6'h00, 1, 0, 1'b0, 1'b0));
        issue(mk(6'h23, 6'h00, 1, NEVER, 1'b0, 1'b0));
        release_rst();
        drain(200);
        quiet(0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
